// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyzer capture path.
// Holds the state encoding and the modulo-DEPTH pointer increment.
package la_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PRE  = 3'd1;
    localparam logic [2:0] ST_POST = 3'd2;
    localparam logic [2:0] ST_DONE = 3'd3;
    localparam logic [2:0] ST_READ = 3'd4;

    // Compare-and-wrap, so DEPTH does not have to be a power of two.
    function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/sdp_bram.sv
// Simple dual-port RAM: one write port and one registered read port.
// Contents are never reset, so the array maps onto block RAM.
module sdp_bram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 49152,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    (* ram_style = "block" *) logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/capture_ring_buffer.sv
// Circular sample-capture buffer with pre-trigger history and valid/ready readout.
// Control and pointer logic live here; storage is the sdp_bram instance.
module capture_ring_buffer
    import la_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 49152,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              arm,
    input  logic              abort,
    input  logic [ADDR_W-1:0] pre_len,
    input  logic [ADDR_W:0]   total_len,
    input  logic              din_valid,
    input  logic [DATA_W-1:0] din,
    input  logic              trigger,
    input  logic              rd_start,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic [2:0]        state,
    output logic              triggered,
    output logic [ADDR_W:0]   stored_count,
    output logic [ADDR_W-1:0] trig_index
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_W   = (ADDR_W+1)'(1);

    logic [2:0]        st;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr, rd_base, pre_cnt, p_lat, trig_idx_r;
    logic [ADDR_W:0]   t_lat, post_rem, rd_left, cnt_r;
    logic              trig_r;
    logic [ADDR_W:0]   t_clamp;
    logic [ADDR_W-1:0] p_clamp;

    logic [1:0]        sk_cnt;
    logic              inflight;
    logic [DATA_W-1:0] head_r, skid_r, ram_q;
    logic [2:0]        occ_next;
    logic              wr_en, pop, issue, read_last;

    always_comb begin
        if (total_len == '0)
            t_clamp = ONE_W;
        else if (total_len > DEPTH_C)
            t_clamp = DEPTH_C;
        else
            t_clamp = total_len;
        if ({1'b0, pre_len} > t_clamp - ONE_W)
            p_clamp = ADDR_W'(t_clamp - ONE_W);
        else
            p_clamp = pre_len;
    end

    assign wr_en = din_valid && !abort && (st == ST_PRE || st == ST_POST);
    assign pop   = (sk_cnt != 2'd0) && rd_ready;
    // Skid entries plus the read in flight never exceed two, so issue keeps one slot per pop.
    assign occ_next  = 3'(sk_cnt) + 3'(inflight) - 3'(pop);
    assign issue     = (st == ST_READ) && !abort && (rd_left != '0) && (occ_next < 3'd2);
    assign read_last = (st == ST_READ) && (rd_left == '0) && !inflight &&
                       ((sk_cnt == 2'd0) || (sk_cnt == 2'd1 && pop));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            st         <= ST_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rd_base    <= '0;
            pre_cnt    <= '0;
            p_lat      <= '0;
            t_lat      <= ONE_W;
            post_rem   <= '0;
            rd_left    <= '0;
            cnt_r      <= '0;
            trig_r     <= 1'b0;
            trig_idx_r <= '0;
        end else if (abort) begin
            st      <= ST_IDLE;
            rd_left <= '0;
        end else begin
            case (st)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        st         <= ST_PRE;
                        t_lat      <= t_clamp;
                        p_lat      <= p_clamp;
                        wr_ptr     <= '0;
                        pre_cnt    <= '0;
                        cnt_r      <= '0;
                        trig_r     <= 1'b0;
                        trig_idx_r <= '0;
                    end else if (st == ST_DONE && rd_start) begin
                        st      <= ST_READ;
                        rd_ptr  <= rd_base;
                        rd_left <= cnt_r;
                    end
                end
                ST_PRE: begin
                    if (din_valid) begin
                        wr_ptr <= ADDR_W'(wrap_inc(32'(wr_ptr), DEPTH));
                        if (trigger) begin
                            trig_r     <= 1'b1;
                            trig_idx_r <= pre_cnt;
                            cnt_r      <= {1'b0, pre_cnt} + ONE_W;
                            post_rem   <= t_lat - {1'b0, pre_cnt} - ONE_W;
                            rd_base    <= (wr_ptr >= pre_cnt) ? wr_ptr - pre_cnt :
                                          ADDR_W'({1'b0, wr_ptr} + DEPTH_C - {1'b0, pre_cnt});
                            st         <= (t_lat - {1'b0, pre_cnt} == ONE_W) ? ST_DONE : ST_POST;
                        end else if (pre_cnt != p_lat) begin
                            pre_cnt <= pre_cnt + ADDR_W'(1);
                            cnt_r   <= {1'b0, pre_cnt} + ONE_W;
                        end
                    end
                end
                ST_POST: begin
                    if (din_valid) begin
                        wr_ptr   <= ADDR_W'(wrap_inc(32'(wr_ptr), DEPTH));
                        post_rem <= post_rem - ONE_W;
                        cnt_r    <= cnt_r + ONE_W;
                        if (post_rem == ONE_W)
                            st <= ST_DONE;
                    end
                end
                ST_READ: begin
                    if (issue) begin
                        rd_ptr  <= ADDR_W'(wrap_inc(32'(rd_ptr), DEPTH));
                        rd_left <= rd_left - ONE_W;
                    end
                    if (read_last)
                        st <= ST_DONE;
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

    // Two-entry output skid: head_r drives dout, skid_r absorbs the read already in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_r   <= '0;
            skid_r   <= '0;
            sk_cnt   <= 2'd0;
            inflight <= 1'b0;
        end else if (abort) begin
            sk_cnt   <= 2'd0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            case ({inflight, pop})
                2'b10: begin
                    if (sk_cnt == 2'd0)
                        head_r <= ram_q;
                    else
                        skid_r <= ram_q;
                    sk_cnt <= sk_cnt + 2'd1;
                end
                2'b01: begin
                    if (sk_cnt == 2'd2)
                        head_r <= skid_r;
                    sk_cnt <= sk_cnt - 2'd1;
                end
                2'b11: begin
                    if (sk_cnt == 2'd1) begin
                        head_r <= ram_q;
                    end else begin
                        head_r <= skid_r;
                        skid_r <= ram_q;
                    end
                end
                default: ;
            endcase
        end
    end

    sdp_bram #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk  (clk),
        .we   (wr_en),
        .waddr(wr_ptr),
        .wdata(din),
        .re   (issue),
        .raddr(rd_ptr),
        .rdata(ram_q)
    );

    assign state        = st;
    assign dout         = head_r;
    assign dout_valid   = (sk_cnt != 2'd0);
    assign triggered    = trig_r;
    assign stored_count = cnt_r;
    assign trig_index   = trig_idx_r;

endmodule

// File: tb/tb_capture_ring_buffer.sv
// Scoreboard bench for capture_ring_buffer at DEPTH=16, DATA_W=8.
// Stimulus queues expected readout words; a negedge monitor pops and compares on each handshake.
module tb_capture_ring_buffer;

    localparam int DW  = 8;
    localparam int DEP = 16;
    localparam int AW  = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          arm = 1'b0, abort = 1'b0, din_valid = 1'b0, trigger = 1'b0;
    logic          rd_start = 1'b0, rd_ready = 1'b0;
    logic [AW-1:0] pre_len = '0;
    logic [AW:0]   total_len = '0;
    logic [DW-1:0] din = '0;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic [2:0]    state;
    logic          triggered;
    logic [AW:0]   stored_count;
    logic [AW-1:0] trig_index;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] exp_q[$];
    bit            chk_stable = 1'b1;
    bit            stall_prev = 1'b0;
    logic [DW-1:0] stall_dout = '0;

    capture_ring_buffer #(
        .DATA_W(DW),
        .DEPTH (DEP)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .arm         (arm),
        .abort       (abort),
        .pre_len     (pre_len),
        .total_len   (total_len),
        .din_valid   (din_valid),
        .din         (din),
        .trigger     (trigger),
        .rd_start    (rd_start),
        .rd_ready    (rd_ready),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .state       (state),
        .triggered   (triggered),
        .stored_count(stored_count),
        .trig_index  (trig_index)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: handshake comparison and stall-stability check.
    always @(negedge clk) begin
        if (resetn && chk_stable && stall_prev) begin
            check("stall_valid", int'(dout_valid), 1);
            check("stall_dout", int'(dout), int'(stall_dout));
        end
        stall_prev = dout_valid && !rd_ready;
        stall_dout = dout;
        if (dout_valid && rd_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL readout_extra: got %0d expected no transfer", dout);
            end else begin
                check("readout", int'(dout), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm(input int p, input int t);
        pre_len   = AW'(p);
        total_len = (AW+1)'(t);
        arm = 1'b1;
        cyc();
        arm = 1'b0;
    endtask

    task automatic send(input int v, input bit trg);
        din       = DW'(v);
        din_valid = 1'b1;
        trigger   = trg;
        cyc();
        din_valid = 1'b0;
        trigger   = 1'b0;
    endtask

    task automatic expect_status(input string tag, input int st, input int cnt, input int tidx);
        check({tag, "_state"}, int'(state), st);
        check({tag, "_stored"}, int'(stored_count), cnt);
        check({tag, "_trig_index"}, int'(trig_index), tidx);
    endtask

    // mode 0: rd_ready held high, latency/throughput checked; mode 1: rd_ready 1,0,0 repeating.
    task automatic readout(input int first, input int n, input int mode);
        bit done = 1'b0;
        for (int i = 0; i < n; i++)
            exp_q.push_back(DW'(first + i));
        rd_ready = (mode == 0);
        rd_start = 1'b1;
        cyc();
        rd_start = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            if (mode == 1)
                rd_ready = (k % 3 == 0);
            cyc();
            if (mode == 0 && k == 1)
                check("first_valid_lat1", int'(dout_valid), 0);
            if (mode == 0 && k == 2)
                check("first_valid_lat2", int'(dout_valid), 1);
            if (state == 3'd3) begin
                if (mode == 0)
                    check("read_cycles", k, n + 2);
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL read_timeout: got state %0d expected 3 within 200 cycles", state);
        end
        check("readout_drained", exp_q.size(), 0);
        rd_ready = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish by 100000ns");
        $fatal(1);
    end

    initial begin
        cyc();
        cyc();
        check("rst_state", int'(state), 0);
        check("rst_dout_valid", int'(dout_valid), 0);
        check("rst_dout", int'(dout), 0);
        check("rst_triggered", int'(triggered), 0);
        check("rst_stored", int'(stored_count), 0);
        check("rst_trig_index", int'(trig_index), 0);
        resetn = 1'b1;
        cyc();

        // arm and trigger together in IDLE: only the arm acts
        pre_len = 4'd3; total_len = 5'd8;
        arm = 1'b1; din_valid = 1'b1; din = 8'hEE; trigger = 1'b1;
        cyc();
        arm = 1'b0; din_valid = 1'b0; trigger = 1'b0;
        expect_status("armtrig", 1, 0, 0);
        check("armtrig_triggered", int'(triggered), 0);

        // T=8, P=3, trigger on sample 10
        for (int i = 0; i < 10; i++)
            send(i, 1'b0);
        expect_status("t1_pre", 1, 3, 0);
        send(10, 1'b1);
        expect_status("t1_trig", 2, 4, 3);
        check("t1_triggered", int'(triggered), 1);
        for (int i = 11; i < 15; i++)
            send(i, 1'b0);
        expect_status("t1_done", 3, 8, 3);
        readout(7, 8, 0);
        readout(7, 8, 0);

        // early trigger on the 2nd sample, P=5, T=8
        do_arm(5, 8);
        expect_status("t2_arm", 1, 0, 0);
        check("t2_arm_triggered", int'(triggered), 0);
        send(100, 1'b0);
        send(101, 1'b1);
        expect_status("t2_trig", 2, 2, 1);
        for (int i = 102; i < 108; i++)
            send(i, 1'b0);
        expect_status("t2_done", 3, 8, 1);
        readout(100, 8, 0);

        // full-depth window across the wrap, stalled readout
        do_arm(15, 16);
        for (int i = 0; i < 40; i++)
            send(i, 1'b0);
        expect_status("t3_pre", 1, 15, 0);
        send(40, 1'b1);
        expect_status("t3_done", 3, 16, 15);
        readout(25, 16, 1);

        // T=1, P=0
        do_arm(0, 1);
        send(50, 1'b1);
        expect_status("t6a_done", 3, 1, 0);
        readout(50, 1, 0);

        // total_len=0 clamps to 1
        do_arm(5, 0);
        send(60, 1'b0);
        expect_status("t6b_pre", 1, 0, 0);
        send(61, 1'b1);
        expect_status("t6b_done", 3, 1, 0);
        readout(61, 1, 0);

        // pre_len >= T clamps to T-1
        do_arm(9, 4);
        for (int i = 70; i < 75; i++)
            send(i, 1'b0);
        send(75, 1'b1);
        expect_status("t6c_done", 3, 4, 3);
        readout(72, 4, 0);

        // abort mid-POST
        do_arm(2, 8);
        for (int i = 1; i < 4; i++)
            send(i, 1'b0);
        send(4, 1'b1);
        send(5, 1'b0);
        check("t5_post_state", int'(state), 2);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        check("t5_abort_post_state", int'(state), 0);
        check("t5_abort_post_valid", int'(dout_valid), 0);

        // abort mid-READ while stalled
        chk_stable = 1'b0;
        do_arm(0, 2);
        send(80, 1'b1);
        check("t5_read_post", int'(state), 2);
        send(81, 1'b0);
        check("t5_read_done", int'(state), 3);
        rd_ready = 1'b0;
        rd_start = 1'b1;
        cyc();
        rd_start = 1'b0;
        cyc();
        cyc();
        check("t5_read_state", int'(state), 4);
        check("t5_read_valid", int'(dout_valid), 1);
        check("t5_read_dout", int'(dout), 80);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        check("t5_abort_read_state", int'(state), 0);
        check("t5_abort_read_valid", int'(dout_valid), 0);

        // asynchronous reset mid-READ
        do_arm(0, 2);
        send(90, 1'b1);
        send(91, 1'b0);
        rd_start = 1'b1;
        cyc();
        rd_start = 1'b0;
        cyc();
        cyc();
        check("t7_pre_rst_valid", int'(dout_valid), 1);
        check("t7_pre_rst_dout", int'(dout), 90);
        resetn = 1'b0;
        #1;
        check("t7_rst_state", int'(state), 0);
        check("t7_rst_valid", int'(dout_valid), 0);
        check("t7_rst_dout", int'(dout), 0);
        check("t7_rst_triggered", int'(triggered), 0);
        check("t7_rst_stored", int'(stored_count), 0);
        check("t7_rst_trig_index", int'(trig_index), 0);
        cyc();
        resetn = 1'b1;
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
